// File: rtl/bank_copy_engine.sv
// Block-copy initiator for the 2048x8 banked memory: reads len bytes from src, writes them to dst.
// Optional BANK_COPY_CHECKSUM_EN adds a 16-bit running sum of all bytes written.
module bank_copy_engine #(
  parameter int AW = 11,
  parameter int DW = 8,
  parameter int LW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          mem_ren,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
`ifdef BANK_COPY_CHECKSUM_EN
  , output logic [15:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LW-1:0] MAXLEN = LW'(1 << AW);

  state_t        state, state_nx;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] rd_left;
  logic          wr_pend;
  logic          conflict, rd_go, wr_go;

  // A sub-bank has a single address port, so a read is held off while the
  // pending write targets the same sub-bank (top 4 address bits).
  always_comb begin
    conflict = wr_pend && (rd_ptr[AW-1:AW-4] == wr_ptr[AW-1:AW-4]);
    rd_go    = (state == RUN) && (rd_left != '0) && !conflict;
    wr_go    = (state == RUN) && wr_pend;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DONE : RUN;
      RUN:     if (rd_left == '0) state_nx = DONE;  // last write, if any, lands this cycle
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rd_left <= '0;
      wr_pend <= 1'b0;
    end else if (state == IDLE) begin
      wr_pend <= 1'b0;
      if (start) begin
        rd_ptr  <= src_addr;
        wr_ptr  <= dst_addr;
        rd_left <= (len > MAXLEN) ? MAXLEN : len;
      end
    end else if (state == RUN) begin
      wr_pend <= rd_go;
      if (rd_go) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_left <= rd_left - LW'(1);
      end
      if (wr_go) wr_ptr <= wr_ptr + AW'(1);
    end else begin
      wr_pend <= 1'b0;
    end
  end

`ifdef BANK_COPY_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          checksum <= '0;
    else if (state == IDLE && start)  checksum <= '0;
    else if (wr_go)                   checksum <= checksum + {{(16-DW){1'b0}}, mem_dout};
  end
`endif

  // Address/data buses are forced to zero whenever the matching enable is low.
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    mem_ren   = rd_go;
    mem_raddr = rd_go ? rd_ptr : '0;
    mem_wen   = wr_go;
    mem_waddr = wr_go ? wr_ptr : '0;
    mem_din   = wr_go ? mem_dout : '0;
  end

endmodule
